wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Writeback stage of the 5-stage RV32 pipeline; sits directly upstream of the three-port register file.
- Holds the MEM/WB pipeline register. Selects the writeback value (ALU result, aligned/extended load data, or PC+4). Drives the register file write port: we3, a3, wd3.
- Also exports the same write as a bypass to decode/execute, flags misaligned or illegal loads, and keeps a 64-bit retired-instruction counter.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- CNT_W, 64, width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  asynchronous active-low reset.
- m_valid  in  1  MEM stage holds a valid instruction.
- m_reg_write  in  1  instruction writes rd.
- m_rd  in  5  destination register.
- m_result_src  in  2  00 ALU, 01 load, 10 PC+4, 11 reserved (treated as ALU).
- m_funct3  in  3  load size/sign: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
- m_alu_result  in  32  ALU result / load effective address.
- m_load_data  in  32  raw aligned 32-bit word from data memory.
- m_pc_plus4  in  32  PC+4 of the instruction.
- stall  in  1  hold the WB register.
- flush  in  1  load a bubble into the WB register.
- rf_we  out  1  to regfile we3.
- rf_a3  out  5  to regfile a3.
- rf_wd  out  32  to regfile wd3.
- fwd_valid  out  1  bypass valid; equals rf_we.
- fwd_rd  out  5  bypass register; equals rf_a3.
- fwd_data  out  32  bypass data; equals rf_wd.
- load_fault  out  1  current WB instruction is a misaligned or illegal-size load.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (async, resetn=0):
  - WB register cleared: w_valid=0, all fields 0.
  - instret=0.
  - All outputs 0.
  - Reset is honoured mid-stall and mid-flush.
- WB register update, each rising edge, in priority order:
  - flush=1: w_valid<=0, other fields don't-care. Flush beats stall.
  - else stall=1: hold all fields.
  - else: capture all m_* inputs (w_valid<=m_valid).
- Latency: one cycle from MEM inputs to rf_*. The register file commits on the following edge. The bypass outputs cover the same-cycle decode read.
- Load extraction is combinational from the registered fields. off = w_alu_result[1:0].
  - lb/lbu: byte at off; sign- or zero-extended.
  - lh/lhu: halfword at off[1]; fault if off[0]=1.
  - lw: full word; fault if off≠0.
  - funct3 011/110/111: fault.
- load_fault = w_valid & (w_result_src==01) & fault condition.
- rf_wd by w_result_src:
  - 00/11: w_alu_result.
  - 01: extracted load value.
  - 10: w_pc_plus4.
- rf_wd is 0 whenever rf_we=0.
- rf_we = w_valid & w_reg_write & (w_rd≠0) & ~load_fault. Writes to x0 are never issued.
- rf_a3 = w_rd when rf_we=1, else 0.
- During stall, rf_we stays asserted with identical a3/wd3. The repeated regfile write is idempotent and intended.
- instret increments by 1 on each edge where w_valid=1 and stall=0, whether or not the instruction wrote or faulted. It wraps modulo 2^CNT_W. Flush does not decrement it.
- Simultaneous flush and stall: flush wins; the bubble holds for the following stall cycles.

Test Plan:
1. Reset. Assert resetn=0 asynchronously between edges → rf_we=0, rf_wd=0, instret=0 immediately. Release; feed m_valid=1, rd=5, ALU src, alu=0x1234 → next cycle rf_we=1, rf_a3=5, rf_wd=0x1234, fwd_* identical; instret=1 after the following edge.
2. Load extraction, m_load_data=0x80FF7F01:
   - lb off=3 → 0xFFFFFF80.
   - lbu off=3 → 0x00000080.
   - lh off=2 → 0xFFFF80FF.
   - lhu off=0 → 0x00007F01.
   - lw off=0 → 0x80FF7F01.
3. Faults: lw alu=0x1002, lh alu=0x1001, funct3=011 → load_fault=1, rf_we=0 each case; instret still increments.
4. x0 suppression and PC+4 source: rd=0, reg_write=1 → rf_we=0. Then jal with rd=1, pc_plus4=0x104 → rf_wd=0x104, rf_we=1.
5. Stall then flush:
   - Stall 3 cycles with valid rd=7 → rf_we=1, a3=7 held for all cycles, instret +1 only after stall drops.
   - Assert flush together with stall → bubble next cycle: rf_we=0, no instret increment.
6. Counter wrap: force instret to 0xFFFF_FFFF_FFFF_FFFF, retire one instruction → 0.

Source files
------------

// File: rtl/wb_stage_if.sv
// wb_stage_if: signal bundle between the MEM/WB boundary and the writeback stage.
//
// Ports / signal groups:
//   MEM side (driven into the stage): m_valid, m_reg_write, m_rd, m_result_src,
//     m_funct3, m_alu_result, m_load_data, m_pc_plus4, plus pipeline control
//     stall and flush.
//   Register file write port: rf_we, rf_a3, rf_wd.
//   Bypass to decode/execute: fwd_valid, fwd_rd, fwd_data.
//   Status: load_fault, instret.
//
// There is no valid/ready pair here. m_valid qualifies the m_* payload on every
// rising edge at which the WB register is neither stalled nor flushed. stall
// and flush are the only back-pressure, and the stage always accepts otherwise.
//
// Modports:
//   mem   - the producer side (MEM stage plus hazard unit), sees outputs.
//   stage - the writeback stage itself.
interface wb_stage_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
);
  logic             m_valid;
  logic             m_reg_write;
  logic [4:0]       m_rd;
  logic [1:0]       m_result_src;
  logic [2:0]       m_funct3;
  logic [XLEN-1:0]  m_alu_result;
  logic [XLEN-1:0]  m_load_data;
  logic [XLEN-1:0]  m_pc_plus4;
  logic             stall;
  logic             flush;

  logic             rf_we;
  logic [4:0]       rf_a3;
  logic [XLEN-1:0]  rf_wd;
  logic             fwd_valid;
  logic [4:0]       fwd_rd;
  logic [XLEN-1:0]  fwd_data;
  logic             load_fault;
  logic [CNT_W-1:0] instret;

  modport mem (
    output m_valid, m_reg_write, m_rd, m_result_src, m_funct3,
           m_alu_result, m_load_data, m_pc_plus4, stall, flush,
    input  rf_we, rf_a3, rf_wd, fwd_valid, fwd_rd, fwd_data,
           load_fault, instret
  );

  modport stage (
    input  m_valid, m_reg_write, m_rd, m_result_src, m_funct3,
           m_alu_result, m_load_data, m_pc_plus4, stall, flush,
    output rf_we, rf_a3, rf_wd, fwd_valid, fwd_rd, fwd_data,
           load_fault, instret
  );
endinterface

// File: rtl/wb_stage.sv
// wb_stage: writeback stage of the 5-stage RV32 pipeline.
//
// Holds the MEM/WB register, selects the writeback value (ALU result,
// aligned/extended load data, or PC+4), drives the register file write port,
// mirrors that write as a bypass, flags misaligned/illegal-size loads and
// counts retired instructions.
//
// Ports:
//   clk    - rising-edge clock.
//   resetn - asynchronous active-low reset.
//   bus    - wb_stage_if.stage: m_* MEM inputs, stall/flush, rf_* write port,
//            fwd_* bypass, load_fault, instret.
module wb_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic        clk,
  input  logic        resetn,
  wb_stage_if.stage   bus
);

  localparam logic [1:0] SRC_ALU  = 2'b00;
  localparam logic [1:0] SRC_LOAD = 2'b01;
  localparam logic [1:0] SRC_PC4  = 2'b10;

  // MEM/WB register fields
  logic             w_valid_q,      w_valid_d;
  logic             w_reg_write_q,  w_reg_write_d;
  logic [4:0]       w_rd_q,         w_rd_d;
  logic [1:0]       w_result_src_q, w_result_src_d;
  logic [2:0]       w_funct3_q,     w_funct3_d;
  logic [XLEN-1:0]  w_alu_result_q, w_alu_result_d;
  logic [XLEN-1:0]  w_load_data_q,  w_load_data_d;
  logic [XLEN-1:0]  w_pc_plus4_q,   w_pc_plus4_d;
  logic [CNT_W-1:0] instret_q,      instret_d;

  // Next-state: flush beats stall, stall beats capture.
  always_comb begin
    w_valid_d      = w_valid_q;
    w_reg_write_d  = w_reg_write_q;
    w_rd_d         = w_rd_q;
    w_result_src_d = w_result_src_q;
    w_funct3_d     = w_funct3_q;
    w_alu_result_d = w_alu_result_q;
    w_load_data_d  = w_load_data_q;
    w_pc_plus4_d   = w_pc_plus4_q;
    if (bus.flush) begin
      // Only the valid bit matters for a bubble; the payload is left as is.
      w_valid_d = 1'b0;
    end else if (!bus.stall) begin
      w_valid_d      = bus.m_valid;
      w_reg_write_d  = bus.m_reg_write;
      w_rd_d         = bus.m_rd;
      w_result_src_d = bus.m_result_src;
      w_funct3_d     = bus.m_funct3;
      w_alu_result_d = bus.m_alu_result;
      w_load_data_d  = bus.m_load_data;
      w_pc_plus4_d   = bus.m_pc_plus4;
    end
  end

  // An instruction retires when it leaves WB: valid and not held by stall.
  // Faulting and non-writing instructions still count.
  always_comb begin
    instret_d = instret_q;
    if (w_valid_q && !bus.stall) begin
      instret_d = instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_valid_q      <= 1'b0;
      w_reg_write_q  <= 1'b0;
      w_rd_q         <= '0;
      w_result_src_q <= '0;
      w_funct3_q     <= '0;
      w_alu_result_q <= '0;
      w_load_data_q  <= '0;
      w_pc_plus4_q   <= '0;
      instret_q      <= '0;
    end else begin
      w_valid_q      <= w_valid_d;
      w_reg_write_q  <= w_reg_write_d;
      w_rd_q         <= w_rd_d;
      w_result_src_q <= w_result_src_d;
      w_funct3_q     <= w_funct3_d;
      w_alu_result_q <= w_alu_result_d;
      w_load_data_q  <= w_load_data_d;
      w_pc_plus4_q   <= w_pc_plus4_d;
      instret_q      <= instret_d;
    end
  end

  // Load extraction. Memory returns the aligned word, so the byte/halfword
  // is picked out by the low address bits.
  logic [1:0]      off;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_value;
  logic            ld_bad;

  assign off = w_alu_result_q[1:0];

  always_comb begin
    ld_byte = w_load_data_q[7:0];
    unique case (off)
      2'd0: ld_byte = w_load_data_q[7:0];
      2'd1: ld_byte = w_load_data_q[15:8];
      2'd2: ld_byte = w_load_data_q[23:16];
      2'd3: ld_byte = w_load_data_q[31:24];
      default: ld_byte = w_load_data_q[7:0];
    endcase
  end

  assign ld_half = off[1] ? w_load_data_q[31:16] : w_load_data_q[15:0];

  always_comb begin
    ld_value = '0;
    ld_bad   = 1'b0;
    case (w_funct3_q)
      3'b000: ld_value = {{24{ld_byte[7]}}, ld_byte};
      3'b100: ld_value = {24'h0, ld_byte};
      3'b001: begin
        ld_value = {{16{ld_half[15]}}, ld_half};
        ld_bad   = off[0];
      end
      3'b101: begin
        ld_value = {16'h0, ld_half};
        ld_bad   = off[0];
      end
      3'b010: begin
        ld_value = w_load_data_q;
        ld_bad   = (off != 2'd0);
      end
      default: ld_bad = 1'b1;  // 011/110/111 are not RV32 loads
    endcase
  end

  logic            fault;
  logic            we;
  logic [XLEN-1:0] wb_value;

  assign fault = w_valid_q && (w_result_src_q == SRC_LOAD) && ld_bad;

  // x0 is never written; a faulting load is dropped.
  assign we = w_valid_q && w_reg_write_q && (w_rd_q != 5'd0) && !fault;

  always_comb begin
    case (w_result_src_q)
      SRC_LOAD: wb_value = ld_value;
      SRC_PC4:  wb_value = w_pc_plus4_q;
      default:  wb_value = w_alu_result_q;  // SRC_ALU and reserved 11
    endcase
  end

  // Address and data are zeroed when no write is issued, so consumers of the
  // bypass never see stale values on an idle port.
  assign bus.rf_we      = we;
  assign bus.rf_a3      = we ? w_rd_q : 5'd0;
  assign bus.rf_wd      = we ? wb_value : '0;
  assign bus.fwd_valid  = bus.rf_we;
  assign bus.fwd_rd     = bus.rf_a3;
  assign bus.fwd_data   = bus.rf_wd;
  assign bus.load_fault = fault;
  assign bus.instret    = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed testbench for wb_stage.
module tb_wb_stage;

  logic clk;
  logic resetn;
  int   checks;
  int   failures;

  wb_stage_if #(.XLEN(32), .CNT_W(64)) bus ();

  wb_stage #(.XLEN(32), .CNT_W(64)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic drive(input logic v, input logic rw, input logic [4:0] rd,
                       input logic [1:0] src, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] ld,
                       input logic [31:0] pc4);
    bus.m_valid      = v;
    bus.m_reg_write  = rw;
    bus.m_rd         = rd;
    bus.m_result_src = src;
    bus.m_funct3     = f3;
    bus.m_alu_result = alu;
    bus.m_load_data  = ld;
    bus.m_pc_plus4   = pc4;
  endtask

  task automatic bubble();
    drive(1'b0, 1'b0, 5'd0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0);
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic we, input logic [4:0] a3,
                        input logic [31:0] wd);
    chk({tag, "_we"}, {63'h0, bus.rf_we}, {63'h0, we});
    chk({tag, "_a3"}, {59'h0, bus.rf_a3}, {59'h0, a3});
    chk({tag, "_wd"}, {32'h0, bus.rf_wd}, {32'h0, wd});
    chk({tag, "_fwd_valid"}, {63'h0, bus.fwd_valid}, {63'h0, we});
    chk({tag, "_fwd_rd"}, {59'h0, bus.fwd_rd}, {59'h0, a3});
    chk({tag, "_fwd_data"}, {32'h0, bus.fwd_data}, {32'h0, wd});
  endtask

  localparam logic [31:0] LD = 32'h80FF7F01;

  initial begin
    checks   = 0;
    failures = 0;
    resetn   = 1'b0;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    bubble();
    repeat (2) step();
    chk("rst_instret", bus.instret, 64'h0);
    chk_wr("rst", 1'b0, 5'd0, 32'h0);
    chk("rst_fault", {63'h0, bus.load_fault}, 64'h0);
    #2 resetn = 1'b1;

    // Load some state, then pull reset between edges.
    drive(1'b1, 1'b1, 5'd4, 2'b00, 3'b000, 32'hAAAA, 32'h0, 32'h0);
    step();
    chk_wr("pre_arst", 1'b1, 5'd4, 32'hAAAA);
    step();
    chk("pre_arst_instret", bus.instret, 64'd1);
    #2 resetn = 1'b0;
    #1;
    chk_wr("arst", 1'b0, 5'd0, 32'h0);
    chk("arst_instret", bus.instret, 64'h0);
    bubble();
    step();
    #2 resetn = 1'b1;

    // 1. Basic ALU writeback and counter latency
    drive(1'b1, 1'b1, 5'd5, 2'b00, 3'b000, 32'h1234, 32'h0, 32'h0);
    step();
    chk_wr("alu", 1'b1, 5'd5, 32'h1234);
    chk("alu_instret0", bus.instret, 64'd0);
    bubble();
    step();
    chk("alu_instret1", bus.instret, 64'd1);
    chk_wr("alu_gone", 1'b0, 5'd0, 32'h0);

    // 2. Load extraction, back-to-back
    drive(1'b1, 1'b1, 5'd10, 2'b01, 3'b000, 32'h1003, LD, 32'h0);
    step();
    chk_wr("lb3", 1'b1, 5'd10, 32'hFFFFFF80);
    chk("lb3_instret", bus.instret, 64'd1);
    drive(1'b1, 1'b1, 5'd10, 2'b01, 3'b100, 32'h1003, LD, 32'h0);
    step();
    chk_wr("lbu3", 1'b1, 5'd10, 32'h00000080);
    drive(1'b1, 1'b1, 5'd10, 2'b01, 3'b001, 32'h1002, LD, 32'h0);
    step();
    chk_wr("lh2", 1'b1, 5'd10, 32'hFFFF80FF);
    drive(1'b1, 1'b1, 5'd10, 2'b01, 3'b101, 32'h1000, LD, 32'h0);
    step();
    chk_wr("lhu0", 1'b1, 5'd10, 32'h00007F01);
    drive(1'b1, 1'b1, 5'd10, 2'b01, 3'b010, 32'h1000, LD, 32'h0);
    step();
    chk_wr("lw0", 1'b1, 5'd10, 32'h80FF7F01);
    chk("lw0_fault", {63'h0, bus.load_fault}, 64'h0);
    chk("lw0_instret", bus.instret, 64'd5);

    // 3. Faulting loads
    drive(1'b1, 1'b1, 5'd11, 2'b01, 3'b010, 32'h1002, LD, 32'h0);
    step();
    chk("lw_mis_fault", {63'h0, bus.load_fault}, 64'h1);
    chk_wr("lw_mis", 1'b0, 5'd0, 32'h0);
    chk("lw_mis_instret", bus.instret, 64'd6);
    drive(1'b1, 1'b1, 5'd11, 2'b01, 3'b001, 32'h1001, LD, 32'h0);
    step();
    chk("lh_mis_fault", {63'h0, bus.load_fault}, 64'h1);
    chk_wr("lh_mis", 1'b0, 5'd0, 32'h0);
    chk("lh_mis_instret", bus.instret, 64'd7);
    drive(1'b1, 1'b1, 5'd11, 2'b01, 3'b011, 32'h1000, LD, 32'h0);
    step();
    chk("f011_fault", {63'h0, bus.load_fault}, 64'h1);
    chk_wr("f011", 1'b0, 5'd0, 32'h0);
    chk("f011_instret", bus.instret, 64'd8);

    // 4. x0 suppression, then PC+4 source
    drive(1'b1, 1'b1, 5'd0, 2'b00, 3'b000, 32'h55, 32'h0, 32'h0);
    step();
    chk_wr("x0", 1'b0, 5'd0, 32'h0);
    chk("x0_fault", {63'h0, bus.load_fault}, 64'h0);
    chk("x0_instret", bus.instret, 64'd9);
    drive(1'b1, 1'b1, 5'd1, 2'b10, 3'b000, 32'hDEAD, 32'h0, 32'h104);
    step();
    chk_wr("jal", 1'b1, 5'd1, 32'h104);
    chk("jal_instret", bus.instret, 64'd10);

    // Reserved source 11 behaves as ALU
    drive(1'b1, 1'b1, 5'd2, 2'b11, 3'b000, 32'hBEEF, LD, 32'h200);
    step();
    chk_wr("src11", 1'b1, 5'd2, 32'hBEEF);
    chk("src11_instret", bus.instret, 64'd11);

    // 5. Stall for three cycles, then flush together with stall
    drive(1'b1, 1'b1, 5'd7, 2'b00, 3'b000, 32'h77, 32'h0, 32'h0);
    step();
    chk_wr("rd7", 1'b1, 5'd7, 32'h77);
    chk("rd7_instret", bus.instret, 64'd12);
    drive(1'b1, 1'b1, 5'd9, 2'b00, 3'b000, 32'h99, 32'h0, 32'h0);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_wr($sformatf("stall%0d", i), 1'b1, 5'd7, 32'h77);
      chk($sformatf("stall%0d_instret", i), bus.instret, 64'd12);
    end
    bus.stall = 1'b0;
    step();
    chk_wr("unstall", 1'b1, 5'd9, 32'h99);
    chk("unstall_instret", bus.instret, 64'd13);
    drive(1'b1, 1'b1, 5'd3, 2'b00, 3'b000, 32'h33, 32'h0, 32'h0);
    bus.stall = 1'b1;
    bus.flush = 1'b1;
    step();
    chk_wr("flush_stall", 1'b0, 5'd0, 32'h0);
    chk("flush_stall_instret", bus.instret, 64'd13);
    bus.flush = 1'b0;
    step();
    chk_wr("bubble_held", 1'b0, 5'd0, 32'h0);
    chk("bubble_held_instret", bus.instret, 64'd13);
    bus.stall = 1'b0;
    bubble();
    step();
    chk_wr("bubble_out", 1'b0, 5'd0, 32'h0);
    chk("bubble_out_instret", bus.instret, 64'd13);

    // 6. Counter wrap
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_q;
    drive(1'b1, 1'b1, 5'd6, 2'b00, 3'b000, 32'h66, 32'h0, 32'h0);
    step();
    chk("wrap_pre", bus.instret, 64'hFFFF_FFFF_FFFF_FFFF);
    chk_wr("wrap_wr", 1'b1, 5'd6, 32'h66);
    bubble();
    step();
    chk("wrap_post", bus.instret, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always ends on its own.
  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
